// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state codes, default constants and IF/ID slot type for the fetch stage
package fetch_pkg;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DROP  = 2'd3;
    localparam logic [31:0] DEFAULT_NOP      = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } slot_t;
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory req/ready handshake
//   req/addr driven by the fetch unit (master), ready/data by memory (slave)
interface fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] data;
    modport master (output req, addr, input ready, data);
    modport slave  (input req, addr, output ready, data);
endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: single-entry {valid, pc, instr} holding buffer for a response that arrives during a stall
//   clk_i/rst_i clock and active-low sync reset; load_i/unload_i/clear_i controls; pc_i/instr_i entry; slot_o contents
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        unload_i,
    input  logic        clear_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output slot_t       slot_o
);
    always_ff @(posedge clk_i) begin
        if (!rst_i)
            slot_o <= '0;
        else if (clear_i || unload_i)
            slot_o.valid <= 1'b0;
        else if (load_i)
            slot_o <= '{1'b1, pc_i, instr_i};
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage owning the PC, the imem handshake FSM and the IF/ID register
//   clk_i/rst_i clock and active-low sync reset; stall_i hold; flush_i/target_i redirect from ID
//   imem master handshake; valid_o/pc_o/instr_o IF/ID register towards decode
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] target_i,
    fetch_if.master     imem,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);
    logic [1:0]  state, state_n;
    logic [31:0] pc, drop_addr;
    slot_t       ifid, skid;
    logic        busy, deliver, skid_load, resume;

    assign busy      = state == FETCH || state == DROP;
    assign deliver   = state == FETCH && imem.ready && !stall_i && !flush_i;
    assign skid_load = state == FETCH && imem.ready && stall_i && !flush_i;
    assign resume    = state == HOLD && !stall_i && !flush_i;
    // DROP keeps presenting the abandoned address while pc already holds the redirect target
    assign imem.req  = busy;
    assign imem.addr = state == DROP ? drop_addr : pc;
    assign valid_o   = ifid.valid;
    assign pc_o      = ifid.pc;
    assign instr_o   = ifid.instr;

    always_comb begin
        state_n = flush_i          ? (busy && !imem.ready ? DROP : FETCH) :
                  state == FETCH   ? (skid_load ? HOLD : FETCH) :
                  state == HOLD    ? (stall_i ? HOLD : FETCH) :
                  state == DROP    ? (imem.ready ? FETCH : DROP) : FETCH;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
            ifid      <= '{1'b0, 32'h0, NOP_INSTR};
        end else begin
            state <= state_n;
            pc    <= flush_i ? word_align(target_i) : (deliver || resume) ? pc + 32'd4 : pc;
            if (flush_i && state == FETCH)
                drop_addr <= pc;
            ifid  <= deliver              ? '{1'b1, pc, imem.data} :
                     resume               ? skid :
                     stall_i && !flush_i  ? ifid : '{1'b0, 32'h0, NOP_INSTR};
        end
    end

    fetch_skid_buf u_skid (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (skid_load),
        .unload_i (resume),
        .clear_i  (flush_i),
        .pc_i     (pc),
        .instr_i  (imem.data),
        .slot_o   (skid)
    );
endmodule
